// File: rtl/dcf77_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dcf77_tx
//  Description : DCF77 minute-frame encoder; one amplitude-key pulse per second.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcf77_tx #(
    parameter int TICKS_SEC = 100,
    parameter int T_ZERO    = 10,
    parameter int T_ONE     = 20,
    parameter int FIXUP     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [58:0] frame_in,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        tx,
    output logic [5:0]  sec_cnt,
    output logic        busy,
    output logic        minute_sync,
    output logic        underrun
);

    localparam int c_tick_w = $clog2(TICKS_SEC);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICKS_SEC - 1);
    localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);
    localparam logic [c_tick_w-1:0] c_zero_last = c_tick_w'(T_ZERO - 1);
    localparam logic [c_tick_w-1:0] c_one_last  = c_tick_w'(T_ONE - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_send = 2'd1;
    localparam logic [1:0] c_mark = 2'd2;

    logic [1:0]          r_state;
    logic [c_tick_w-1:0] r_tick;
    logic [5:0]          r_sec_cnt;
    logic [58:0]         r_shift;
    logic [58:0]         r_buf;
    logic                r_full;
    logic                r_tx;
    logic                r_ms_flag;
    logic                r_underrun;

    logic [58:0]         w_load_frame;
    logic [c_tick_w-1:0] w_last_high;

    // Marker bits and even-parity bits are regenerated so the receiver always sees a legal frame.
    generate
        if (FIXUP != 0) begin : g_fixup
            always_comb begin
                w_load_frame     = r_buf;
                w_load_frame[0]  = 1'b0;
                w_load_frame[20] = 1'b1;
                w_load_frame[28] = ^r_buf[27:21];
                w_load_frame[35] = ^r_buf[34:29];
                w_load_frame[58] = ^r_buf[57:36];
            end
        end else begin : g_nofixup
            assign w_load_frame = r_buf;
        end
    endgenerate

    assign w_last_high = r_shift[0] ? c_one_last : c_zero_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_tick     <= '0;
            r_sec_cnt  <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_full     <= 1'b0;
            r_tx       <= 1'b0;
            r_ms_flag  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (frame_valid && !r_full) begin
                r_buf  <= frame_in;
                r_full <= 1'b1;
            end
            if (clk_en) begin
                r_ms_flag <= 1'b0;
                case (r_state)
                    c_idle: begin
                        if (r_full) begin
                            r_shift   <= w_load_frame;
                            r_full    <= 1'b0;
                            r_sec_cnt <= '0;
                            r_tick    <= '0;
                            r_tx      <= 1'b1;
                            r_ms_flag <= 1'b1;
                            r_state   <= c_send;
                        end
                    end
                    c_send: begin
                        if (r_tick == c_tick_last) begin
                            r_tick  <= '0;
                            r_shift <= {1'b0, r_shift[58:1]};
                            if (r_sec_cnt == 6'd58) begin
                                r_sec_cnt <= 6'd59;
                                r_tx      <= 1'b0;
                                r_state   <= c_mark;
                            end else begin
                                r_sec_cnt <= r_sec_cnt + 6'd1;
                                r_tx      <= 1'b1;
                            end
                        end else begin
                            r_tick <= r_tick + c_tick_one;
                            if (r_tick == w_last_high) begin
                                r_tx <= 1'b0;
                            end
                        end
                    end
                    c_mark: begin
                        if (r_tick == c_tick_last) begin
                            r_tick    <= '0;
                            r_sec_cnt <= '0;
                            if (r_full) begin
                                r_shift   <= w_load_frame;
                                r_full    <= 1'b0;
                                r_tx      <= 1'b1;
                                r_ms_flag <= 1'b1;
                                r_state   <= c_send;
                            end else begin
                                r_underrun <= 1'b1;
                                r_state    <= c_idle;
                            end
                        end else begin
                            r_tick <= r_tick + c_tick_one;
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                    end
                endcase
            end
        end
    end

    assign frame_ready = !r_full;
    assign tx          = r_tx;
    assign sec_cnt     = r_sec_cnt;
    assign busy        = (r_state != c_idle);
    assign minute_sync = r_ms_flag & clk_en;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dcf77_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcf77_tx
//  Description : Scoreboard bench for dcf77_tx against a per-minute pulse model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcf77_tx;

    localparam int TICKS_SEC = 100;
    localparam int T_ZERO    = 10;
    localparam int T_ONE     = 20;
    localparam int MINUTE    = 60 * TICKS_SEC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_en = 1'b0;
    logic [58:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        tx;
    logic [5:0]  sec_cnt;
    logic        busy;
    logic        minute_sync;
    logic        underrun;

    dcf77_tx #(
        .TICKS_SEC(TICKS_SEC),
        .T_ZERO   (T_ZERO),
        .T_ONE    (T_ONE),
        .FIXUP    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .tx         (tx),
        .sec_cnt    (sec_cnt),
        .busy       (busy),
        .minute_sync(minute_sync),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Tick enable: high for every second rising edge, changed away from both edges.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            clk_en = ~clk_en;
        end
    end

    typedef struct {
        int unsigned rise;
        int unsigned width;
        int unsigned sec;
    } pulse_t;

    pulse_t      q_pulse[$];
    int unsigned q_sync[$];
    int unsigned tc = 0;
    int unsigned m_cur_end = 0;
    bit          m_pend = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tc);
        end
    endtask

    task automatic note_fail(input string name, input longint unsigned val);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: value %0d (tick %0d)", name, val, tc);
    endtask

    function automatic logic [58:0] fixup(input logic [58:0] f);
        logic [58:0] g;
        int ones;
        g     = f;
        g[0]  = 1'b0;
        g[20] = 1'b1;
        ones = 0;
        for (int i = 21; i <= 27; i++) ones += int'(f[i]);
        g[28] = (ones % 2) == 1;
        ones = 0;
        for (int i = 29; i <= 34; i++) ones += int'(f[i]);
        g[35] = (ones % 2) == 1;
        ones = 0;
        for (int i = 36; i <= 57; i++) ones += int'(f[i]);
        g[58] = (ones % 2) == 1;
        return g;
    endfunction

    function automatic logic [58:0] rand59();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[58:0];
    endfunction

    task automatic push_minute(input int unsigned start, input logic [58:0] f);
        logic [58:0] fx;
        fx = fixup(f);
        for (int s = 0; s < 59; s++) begin
            q_pulse.push_back('{start + TICKS_SEC * s, fx[s] ? T_ONE : T_ZERO, s});
        end
        q_sync.push_back(start + 1);
    endtask

    // Offer a frame on a non-tick edge; the model decides when that minute starts.
    task automatic send_frame(input logic [58:0] f);
        @(negedge clk);
        while (clk_en) @(negedge clk);
        check("frame_ready_offer", frame_ready, !m_pend);
        frame_valid = 1'b1;
        frame_in    = f;
        @(negedge clk);
        frame_valid = 1'b0;
        if (m_cur_end > tc) begin
            push_minute(m_cur_end, f);
            m_pend = 1'b1;
        end else begin
            push_minute(tc + 1, f);
            m_cur_end = tc + 1 + MINUTE;
        end
    endtask

    task automatic wait_tc(input int unsigned n);
        while (tc < n) @(negedge clk);
    endtask

    task automatic model_clear();
        q_pulse.delete();
        q_sync.delete();
        m_cur_end = 0;
        m_pend    = 1'b0;
    endtask

    // Tick-edge monitor: pulse scoreboard and underrun prediction.
    initial begin : mon_edge
        bit          in_pulse;
        bit          en_at;
        bit          rst_at;
        bit          exp_u;
        int unsigned rise;
        int unsigned rsec;
        logic        rbusy;
        pulse_t      p;
        in_pulse = 1'b0;
        rise = 0;
        rsec = 0;
        rbusy = 1'b0;
        forever begin
            @(posedge clk);
            en_at  = clk_en;
            rst_at = reset;
            #1;
            if (en_at) tc++;
            if (rst_at) begin
                in_pulse = 1'b0;
            end else if (en_at) begin
                exp_u = 1'b0;
                if (m_cur_end != 0 && tc == m_cur_end) begin
                    if (m_pend) begin
                        m_pend    = 1'b0;
                        m_cur_end = tc + MINUTE;
                    end else begin
                        exp_u     = 1'b1;
                        m_cur_end = 0;
                    end
                end
                if (underrun || exp_u) begin
                    check("underrun", underrun, exp_u);
                    if (exp_u) check("idle_after_underrun", {busy, sec_cnt}, 7'd0);
                end
                if (tx && !in_pulse) begin
                    in_pulse = 1'b1;
                    rise     = tc;
                    rsec     = sec_cnt;
                    rbusy    = busy;
                end else if (!tx && in_pulse) begin
                    in_pulse = 1'b0;
                    if (q_pulse.size() == 0) begin
                        note_fail("pulse_unexpected_rise", rise);
                    end else begin
                        p = q_pulse.pop_front();
                        check("pulse_rise", rise, p.rise);
                        check("pulse_width", tc - rise, p.width);
                        check("pulse_sec", rsec, p.sec);
                        check("pulse_busy", rbusy, 1);
                    end
                end
                while (!in_pulse && q_pulse.size() > 0 && q_pulse[0].rise < tc) begin
                    p = q_pulse.pop_front();
                    note_fail("pulse_missing_rise", p.rise);
                end
            end
        end
    end

    // minute_sync is combinational with clk_en, so it is sampled ahead of the tick edge.
    initial begin : mon_sync
        bit exp_s;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && clk_en) begin
                while (q_sync.size() > 0 && q_sync[0] < tc + 1) begin
                    note_fail("minute_sync_missing", q_sync.pop_front());
                end
                exp_s = (q_sync.size() > 0) && (q_sync[0] == tc + 1);
                if (minute_sync || exp_s) begin
                    check("minute_sync", minute_sync, exp_s);
                    if (exp_s) void'(q_sync.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned s_a;
        int unsigned s_c;
        int unsigned s_d;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx", tx, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_ready", frame_ready, 1);
        check("rst_sec_cnt", sec_cnt, 0);
        check("rst_minute_sync", minute_sync, 0);
        check("rst_underrun", underrun, 0);

        wait_tc(tc + 500);
        check("idle_busy", busy, m_cur_end != 0);
        check("idle_tx", tx, 0);
        check("idle_sec_cnt", sec_cnt, 0);

        // Widths, minute mark, back-to-back minute, then underrun.
        send_frame(59'h2);
        s_a = m_cur_end - MINUTE;
        wait_tc(s_a + 10 * TICKS_SEC + 37);
        send_frame(rand59());
        check("frame_ready_pending", frame_ready, !m_pend);
        wait_tc(s_a + 2 * MINUTE + 20);
        check("post_underrun_busy", busy, m_cur_end != 0);
        check("post_underrun_ready", frame_ready, !m_pend);

        // Reset in the middle of the second-3 pulse with a frame waiting.
        wait_tc(tc + $urandom_range(5, 50));
        send_frame(rand59());
        s_c = m_cur_end - MINUTE;
        wait_tc(s_c + 150);
        send_frame(rand59());
        wait_tc(s_c + 3 * TICKS_SEC + 5);
        check("tx_before_reset", tx, 1);
        reset = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check("midrst_tx", tx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sec_cnt", sec_cnt, 0);
        check("midrst_frame_ready", frame_ready, 1);
        check("midrst_minute_sync", minute_sync, 0);
        check("midrst_underrun", underrun, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_tc(tc + 300);
        check("after_reset_busy", busy, m_cur_end != 0);

        // Follow-on frame arriving during the minute mark must still join seamlessly.
        send_frame(rand59());
        s_d = m_cur_end - MINUTE;
        wait_tc(s_d + MINUTE - 50);
        send_frame(rand59());
        wait_tc(s_d + 2 * MINUTE + 10);
        check("final_busy", busy, m_cur_end != 0);
        check("pulses_drained", q_pulse.size(), 0);
        check("syncs_drained", q_sync.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
